// File: rtl/kmul_pkg.sv
// Shared constants and result bundle for the Karatsuba multiplier arbiter.
// Operand/product widths match the karatsuba_34x43 datapath.
package kmul_pkg;

  localparam int KM_AW  = 34;
  localparam int KM_BW  = 43;
  localparam int KM_CW  = 77;
  localparam int KM_IDW = 3;

  typedef struct packed {
    logic [KM_IDW-1:0] id;
    logic [KM_CW-1:0]  data;
  } kmul_res_t;

endpackage

// File: rtl/kmul_res_fifo.sv
// Result FIFO: registered occupancy, no fall-through.
// Head holds the last popped entry while empty.
module kmul_res_fifo
  import kmul_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  kmul_res_t              din,
  input  logic                   pop,
  output logic                   valid,
  output kmul_res_t              dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kmul_res_t       mem [DEPTH];
  kmul_res_t       hold;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            take;

  assign valid = count != '0;
  assign take  = pop & valid;
  assign dout  = valid ? mem[rp] : hold;

  // storage array, written on push
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // pointers, occupancy and last-popped hold register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      hold  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (take) begin
        rp   <= rp + 1'b1;
        hold <= mem[rp];
      end
      count <= count + CW'(push) - CW'(take);
    end
  end

endmodule

// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin front end for a shared pipelined 34x43 multiplier.
// Optional stat_issue/stat_stall counters: define KMUL_ARB_STATS_EN.
module karatsuba_mul_arbiter
  import kmul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 5,
  parameter int FIFO_DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*KM_AW-1:0]   req_a,
  input  logic [NREQ*KM_BW-1:0]   req_b,
  output logic [KM_AW-1:0]        mul_a,
  output logic [KM_BW-1:0]        mul_b,
  input  logic [KM_CW-1:0]        mul_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [KM_CW-1:0]        res_data,
`ifdef KMUL_ARB_STATS_EN
  output logic [31:0]             stat_issue,
  output logic [31:0]             stat_stall,
`endif
  output logic [$clog2(NREQ)-1:0] res_id
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]              rr_ptr;
  logic [IW-1:0]              gnt_id;
  logic                       found;
  logic                       has_credit;
  logic                       issue;
  int                         avail;
  logic [MUL_LAT:0]           tag_v;
  logic [MUL_LAT:0][IW-1:0]   tag_id;
  logic [$clog2(FIFO_DW):0]   fcount;
  kmul_res_t                  push_d;
  kmul_res_t                  head;
  logic                       id_unused;

  // first valid requester after rr_ptr, wrapping
  always_comb begin
    logic [IW-1:0] idx;
    found  = 1'b0;
    gnt_id = rr_ptr;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // free slots = depth minus buffered minus in flight
  always_comb begin
    avail      = FIFO_DW - int'(fcount) - $countones(tag_v);
    has_credit = avail > 0;
  end

  assign issue = rst & found & has_credit;

  // one-hot accept for the winner
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  // operand register, tag pipeline and rr pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      rr_ptr <= IW'(NREQ - 1);
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[MUL_LAT-1:0], issue};
      tag_id <= {tag_id[MUL_LAT-1:0], gnt_id};
      if (issue) begin
        rr_ptr <= gnt_id;
        for (int i = 0; i < NREQ; i++) begin
          if (gnt_id == IW'(i)) begin
            mul_a <= req_a[i*KM_AW +: KM_AW];
            mul_b <= req_b[i*KM_BW +: KM_BW];
          end
        end
      end
    end
  end

  assign push_d = '{id: KM_IDW'(tag_id[MUL_LAT]), data: mul_c};

  kmul_res_fifo #(
    .DEPTH (FIFO_DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_v[MUL_LAT]),
    .din   (push_d),
    .pop   (res_ready),
    .valid (res_valid),
    .dout  (head),
    .count (fcount)
  );

  assign res_data  = head.data;
  assign res_id    = head.id[IW-1:0];
  assign id_unused = ^head.id;

`ifdef KMUL_ARB_STATS_EN
  // issue and credit-stall counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (issue) stat_issue <= stat_issue + 32'd1;
      if (|req_valid && !has_credit) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
